// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and control bundle for the unified-memory arbiter.
//   slave : arbiter side (takes requests, drives memory and completion/stall)
//   master: core/memory side (drives requests, memory read data and hlt)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [2:0]        dm_wcontrol;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              hlt;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_wcontrol;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              halted;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wcontrol, hlt, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
           mem_wcontrol, stall, halted
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wcontrol, hlt, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata,
           mem_wcontrol, stall, halted
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sequencer for a single-port memory shared by fetch (IF) and load/store (DM).
//   clk/rst : clock, synchronous active-high reset
//   bus     : requests in, registered rdata/ready pulses out, mem_* access port, stall/halted out
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  localparam logic [1:0] IDLE = 2'd0, IF_ACC = 2'd1, DM_ACC = 2'd2, HALTED = 2'd3;
  localparam logic [2:0] NO_WR = 3'd7;
  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              last_dm_q, last_dm_d;
  logic              if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_wcontrol_q, mem_wcontrol_d;
  logic              if_v, dm_v, pick_dm, last_cyc, halted;
  // a port whose ready is showing is masked so its still-high req cannot re-launch the same access
  assign if_v     = bus.if_req & ~if_ready_q;
  assign dm_v     = bus.dm_req & ~dm_ready_q;
  assign pick_dm  = dm_v & (~if_v | ~last_dm_q);
  assign last_cyc = cnt_q == CW'(MEM_LAT - 1);
  assign halted   = state_q == HALTED;
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_dm_d      = last_dm_q;
    if_ready_d     = 1'b0;
    dm_ready_d     = 1'b0;
    if_rdata_d     = if_rdata_q;
    dm_rdata_d     = dm_rdata_q;
    mem_en_d       = mem_en_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wcontrol_d = mem_wcontrol_q;
    case (state_q)
      IDLE: begin
        if (bus.hlt) state_d = HALTED;
        else if (if_v | dm_v) begin
          state_d        = pick_dm ? DM_ACC : IF_ACC;
          cnt_d          = '0;
          last_dm_d      = pick_dm;
          mem_en_d       = 1'b1;
          mem_we_d       = pick_dm & bus.dm_we;
          mem_addr_d     = pick_dm ? bus.dm_addr : bus.if_addr;
          mem_wdata_d    = pick_dm ? bus.dm_wdata : '0;
          mem_wcontrol_d = pick_dm ? bus.dm_wcontrol : NO_WR;
        end
      end
      IF_ACC, DM_ACC: begin
        cnt_d = cnt_q + CW'(1);
        if (last_cyc) begin
          if_ready_d     = state_q == IF_ACC;
          dm_ready_d     = state_q == DM_ACC;
          if_rdata_d     = state_q == IF_ACC ? bus.mem_rdata : if_rdata_q;
          dm_rdata_d     = (state_q == DM_ACC && !mem_we_q) ? bus.mem_rdata : dm_rdata_q;
          mem_en_d       = 1'b0;
          mem_we_d       = 1'b0;
          mem_wcontrol_d = NO_WR;
          state_d        = bus.hlt ? HALTED : IDLE;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      last_dm_q      <= 1'b0;
      if_ready_q     <= 1'b0;
      dm_ready_q     <= 1'b0;
      if_rdata_q     <= '0;
      dm_rdata_q     <= '0;
      mem_en_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wcontrol_q <= NO_WR;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_dm_q      <= last_dm_d;
      if_ready_q     <= if_ready_d;
      dm_ready_q     <= dm_ready_d;
      if_rdata_q     <= if_rdata_d;
      dm_rdata_q     <= dm_rdata_d;
      mem_en_q       <= mem_en_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wcontrol_q <= mem_wcontrol_d;
    end
  end
  assign bus.if_rdata     = if_rdata_q;
  assign bus.if_ready     = if_ready_q;
  assign bus.dm_rdata     = dm_rdata_q;
  assign bus.dm_ready     = dm_ready_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.mem_wcontrol = mem_wcontrol_q;
  assign bus.halted       = halted;
  assign bus.stall        = ~halted & ((bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboarded bench for mem_arbiter with a latency-accurate memory model.
module tb_mem_arbiter;
  localparam int LAT = 2;
  typedef struct { logic dm; logic [31:0] data; } exp_t;
  typedef struct { logic dm; logic we; logic [31:0] addr; logic [31:0] wdata; logic [2:0] wctl; } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int en_run = 0;
  exp_t sb[$];
  exp_t e;
  logic [31:0] shadow_dm;
  vec_t vt[6];
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h00500093;
      32'h14:  return 32'h00A00113;
      32'h200: return 32'hDEADBEEF;
      default: return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endcase
  endfunction
  // read data is only valid in the last access cycle; anything else returns a poison word
  always @(posedge clk) en_run <= bus.mem_en ? en_run + 1 : 0;
  assign bus.mem_rdata = (bus.mem_en && en_run == LAT - 1) ? model(bus.mem_addr) : 32'hBAD0BAD0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic dm, input logic [31:0] d);
    exp_t x;
    x.dm = dm;
    x.data = d;
    sb.push_back(x);
  endtask
  always @(negedge clk) begin
    if (bus.if_ready === 1'b1 || bus.dm_ready === 1'b1) begin
      chk("ready_exclusive", 32'(bus.if_ready & bus.dm_ready), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: if_ready=%b dm_ready=%b with empty scoreboard at %0t", bus.if_ready, bus.dm_ready, $time);
      end else begin
        e = sb.pop_front();
        chk("ready_port", 32'(bus.dm_ready), 32'(e.dm));
        chk(e.dm ? "dm_rdata" : "if_rdata", e.dm ? bus.dm_rdata : bus.if_rdata, e.data);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vt[0] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 3'd2};
    vt[1] = '{1'b0, 1'b0, 32'h100, 32'h0, 3'd7};
    vt[2] = '{1'b1, 1'b0, 32'h300, 32'h0, 3'd7};
    vt[3] = '{1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 3'd0};
    vt[4] = '{1'b0, 1'b0, 32'h14, 32'h0, 3'd7};
    vt[5] = '{1'b1, 1'b0, 32'h44, 32'h0, 3'd7};
    bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = 0; bus.dm_wdata = 0; bus.dm_wcontrol = 7; bus.hlt = 0;
    // reset with random inputs
    rst = 1;
    tick();
    bus.if_req = 1'($urandom); bus.dm_req = 1'($urandom); bus.hlt = 1'($urandom);
    bus.if_addr = $urandom; bus.dm_addr = $urandom; bus.dm_wdata = $urandom; bus.dm_we = 1'($urandom);
    @(negedge clk);
    chk("rst_if_ready", 32'(bus.if_ready), 0);
    chk("rst_dm_ready", 32'(bus.dm_ready), 0);
    chk("rst_if_rdata", bus.if_rdata, 0);
    chk("rst_dm_rdata", bus.dm_rdata, 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_wcontrol", 32'(bus.mem_wcontrol), 7);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_stall", 32'(bus.stall), 32'(bus.if_req | bus.dm_req));
    tick();
    rst = 0; bus.if_req = 0; bus.dm_req = 0; bus.hlt = 0; bus.dm_we = 0;
    // single fetch, cycle 1
    bus.if_req = 1; bus.if_addr = 32'h10;
    push(0, 32'h00500093);
    @(negedge clk);
    chk("fetch_c1_stall", 32'(bus.stall), 1);
    chk("fetch_c1_mem_en", 32'(bus.mem_en), 0);
    tick();
    @(negedge clk);
    chk("fetch_c2_mem_en", 32'(bus.mem_en), 1);
    chk("fetch_c2_mem_addr", bus.mem_addr, 32'h10);
    chk("fetch_c2_stall", 32'(bus.stall), 1);
    tick();
    @(negedge clk);
    chk("fetch_c3_mem_en", 32'(bus.mem_en), 1);
    chk("fetch_c3_mem_addr", bus.mem_addr, 32'h10);
    chk("fetch_c3_stall", 32'(bus.stall), 1);
    tick();
    @(negedge clk);
    chk("fetch_c4_if_ready", 32'(bus.if_ready), 1);
    chk("fetch_c4_stall", 32'(bus.stall), 0);
    chk("fetch_c4_mem_en", 32'(bus.mem_en), 0);
    bus.if_req = 0;
    tick();
    tick();
    @(negedge clk);
    chk("fetch_no_dup", 32'(bus.mem_en), 0);
    chk("fetch_ready_once", 32'(bus.if_ready), 0);
    // round-robin conflict from reset
    rst = 1;
    bus.if_req = 1; bus.if_addr = 32'h14;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h200; bus.dm_wcontrol = 7;
    tick();
    tick();
    rst = 0;
    push(1, 32'hDEADBEEF); push(0, 32'h00A00113); push(1, 32'hDEADBEEF); push(0, 32'h00A00113);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      chk($sformatf("rr_c%0d_dm_ready", c), 32'(bus.dm_ready), 32'(c == 4 || c == 10));
      chk($sformatf("rr_c%0d_if_ready", c), 32'(bus.if_ready), 32'(c == 7 || c == 13));
      if (c == 2 || c == 8) chk($sformatf("rr_c%0d_addr", c), bus.mem_addr, 32'h200);
      if (c == 5 || c == 11) chk($sformatf("rr_c%0d_addr", c), bus.mem_addr, 32'h14);
      if (c == 13) begin bus.if_req = 0; bus.dm_req = 0; end
      tick();
    end
    tick();
    chk("rr_idle_after", 32'(bus.mem_en), 0);
    chk("rr_sb_drained", sb.size(), 0);
    // table-driven single accesses with inputs scrambled after grant
    shadow_dm = 32'hDEADBEEF;
    for (int i = 0; i < 6; i++) begin
      bus.if_req = !vt[i].dm; bus.if_addr = vt[i].addr;
      bus.dm_req = vt[i].dm; bus.dm_we = vt[i].we; bus.dm_addr = vt[i].addr;
      bus.dm_wdata = vt[i].wdata; bus.dm_wcontrol = vt[i].wctl;
      if (vt[i].dm && !vt[i].we) shadow_dm = model(vt[i].addr);
      push(vt[i].dm, vt[i].dm && vt[i].we ? shadow_dm : model(vt[i].addr));
      for (int k = 0; k < 8 && bus.mem_en !== 1'b1; k++) tick();
      chk($sformatf("v%0d_granted", i), 32'(bus.mem_en), 1);
      for (int r = 0; r < LAT; r++) begin
        chk($sformatf("v%0d_r%0d_addr", i, r), bus.mem_addr, vt[i].addr);
        chk($sformatf("v%0d_r%0d_we", i, r), 32'(bus.mem_we), 32'(vt[i].dm & vt[i].we));
        chk($sformatf("v%0d_r%0d_wctl", i, r), 32'(bus.mem_wcontrol), vt[i].dm ? 32'(vt[i].wctl) : 32'd7);
        if (vt[i].dm) chk($sformatf("v%0d_r%0d_wdata", i, r), bus.mem_wdata, vt[i].wdata);
        bus.if_addr = ~vt[i].addr; bus.dm_addr = ~vt[i].addr; bus.dm_wdata = ~vt[i].wdata;
        bus.dm_we = ~vt[i].we; bus.dm_wcontrol = 3'd5;
        tick();
      end
      for (int k = 0; k < 8 && bus.if_ready !== 1'b1 && bus.dm_ready !== 1'b1; k++) tick();
      chk($sformatf("v%0d_ready", i), 32'(vt[i].dm ? bus.dm_ready : bus.if_ready), 1);
      chk($sformatf("v%0d_end_en", i), 32'(bus.mem_en), 0);
      chk($sformatf("v%0d_end_we", i), 32'(bus.mem_we), 0);
      chk($sformatf("v%0d_end_wctl", i), 32'(bus.mem_wcontrol), 7);
      bus.if_req = 0; bus.dm_req = 0;
      tick();
      chk($sformatf("v%0d_no_dup", i), 32'(bus.mem_en), 0);
    end
    chk("tab_sb_drained", sb.size(), 0);
    // reset in the first DM_ACC cycle aborts the access
    rst = 1;
    tick();
    tick();
    rst = 0;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h300; bus.dm_wcontrol = 7;
    tick();
    chk("abort_started", 32'(bus.mem_en), 1);
    rst = 1; bus.dm_req = 0;
    tick();
    chk("abort_mem_en", 32'(bus.mem_en), 0);
    rst = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_no_ready", 32'(bus.dm_ready), 0);
      chk("abort_dm_rdata", bus.dm_rdata, 0);
    end
    // halt during IF_ACC
    bus.if_req = 1; bus.if_addr = 32'h10;
    push(0, 32'h00500093);
    tick();
    chk("halt_in_access", 32'(bus.mem_en), 1);
    bus.hlt = 1;
    tick();
    tick();
    chk("halt_if_ready", 32'(bus.if_ready), 1);
    chk("halt_halted", 32'(bus.halted), 1);
    chk("halt_stall", 32'(bus.stall), 0);
    bus.hlt = 0; bus.dm_req = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("halted_mem_en", 32'(bus.mem_en), 0);
      chk("halted_stall", 32'(bus.stall), 0);
      chk("halted_stays", 32'(bus.halted), 1);
      chk("halted_no_ready", 32'(bus.if_ready | bus.dm_ready), 0);
    end
    chk("halted_if_rdata_held", bus.if_rdata, 32'h00500093);
    rst = 1;
    tick();
    rst = 0;
    chk("unhalt_halted", 32'(bus.halted), 0);
    chk("unhalt_stall", 32'(bus.stall), 1);
    bus.if_req = 0; bus.dm_req = 0;
    tick();
    tick();
    chk("unhalt_idle", 32'(bus.mem_en), 0);
    chk("final_sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single-port unified instruction/data memory shared by two requesters: the fetch stage (IF port) and the load/store unit (DM port).
- Grants one fixed-latency access at a time using round-robin priority, latches request fields, and counts out memory latency.
- Returns read data with a one-cycle ready pulse and drives a global stall to the core.
- Honours the controller's hlt signal by entering a terminal HALTED state.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, memory access cycles from issue to data valid (legal range >= 1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch request
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched instruction (registered)
if_ready  out  1  one-cycle fetch completion pulse
dm_req  in  1  load/store request
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  store data
dm_wcontrol  in  3  store width code (writecontrol encoding; 7 = no write)
dm_rdata  out  DATA_W  load data (registered)
dm_ready  out  1  one-cycle data completion pulse
hlt  in  1  halt request from the controller
mem_en  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wcontrol  out  3  memory write width code
mem_rdata  in  DATA_W  memory read data, valid in the last access cycle
stall  out  1  core stall
halted  out  1  arbiter is in HALTED

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE; cnt=0; last_grant=IF; all registered outputs 0, including if_rdata, dm_rdata, mem_*; mem_wcontrol=7; halted=0.
- States: IDLE, IF_ACC, DM_ACC, HALTED.
- IDLE:
  - hlt=1 -> HALTED. hlt has priority over any request.
  - Else if exactly one unmasked request -> grant it.
  - Else if both -> grant the port opposite last_grant.
  - On grant: latch addr/wdata/we/wcontrol into mem_* registers, cnt<=0, last_grant<=port, go to X_ACC.
  - IF grants force mem_we=0 and mem_wcontrol=7.
- X_ACC:
  - mem_en=1; mem_* held stable for exactly MEM_LAT cycles; cnt increments each cycle.
  - When cnt==MEM_LAT-1: capture mem_rdata into the granted port's rdata (loads/fetches only; a store leaves dm_rdata unchanged).
  - In the same cycle, set that port's ready pulse for the next cycle, clear mem_en/mem_we, mem_wcontrol<=7.
  - Next state: HALTED if hlt=1, else IDLE.
- Latency: request present in IDLE at cycle t -> mem_en high t+1..t+MEM_LAT -> ready high at t+MEM_LAT+1. With MEM_LAT=2, ready is at t+3.
- Masking: in the cycle a port's ready is high, that port's req is ignored for arbitration. The requester has that cycle to drop or change req, which prevents a duplicate access. The other port can still be granted in that cycle.
- Request sampling: req is sampled only in IDLE. Deasserting req during X_ACC does not abort; ready still pulses. Input addr/data changes after grant have no effect.
- stall = ~halted & ((if_req & ~if_ready) | (dm_req & ~dm_ready)). Combinational.
- HALTED: terminal until rst. mem_en=0, no grants, ready outputs 0, halted=1, stall=0. rdata registers hold their values.
- Reset mid-access: a synchronous rst during X_ACC aborts the access. mem_en=0 from the next cycle; no ready pulse; nothing captured.
- Ready pulses are exactly one cycle and never asserted simultaneously.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0, mem_wcontrol=7, halted=0, stall follows reqs.
- Single fetch (MEM_LAT=2): if_req=1, if_addr=0x10 at cycle 1, mem_rdata=0x00500093 in cycle 3 -> mem_en=1/mem_addr=0x10 in cycles 2-3; if_ready=1 and if_rdata=0x00500093 in cycle 4; stall=1 in cycles 1-3; no second access if req is dropped in cycle 4.
- Conflict round-robin: both reqs held from reset, dm_addr=0x200 load returning 0xDEADBEEF, if_addr=0x14 -> DM served first (dm_ready cycle 4), IF granted in cycle 4 (if_ready cycle 7); with reqs re-asserted, the next two conflicts alternate DM, IF.
- Store: dm_we=1, dm_wcontrol=2, dm_addr=0x40, dm_wdata=0x12345678; inputs changed after grant -> mem_we=1 with fields stable for 2 cycles; dm_ready pulse; dm_rdata unchanged; mem_wcontrol back to 7.
- Reset mid-access: rst in the first DM_ACC cycle -> mem_en=0 next cycle; no dm_ready; dm_rdata=0.
- Halt: hlt=1 during IF_ACC -> if_ready still pulses with data; halted=1 afterward; later reqs cause no mem_en; stall=0; rst returns the arbiter to IDLE.
